inter_frame_space: RTL and testbench

Tracks the CAN interframe space that follows each received or transmitted frame. After the frame builder signals completion, it checks the 3-bit intermission field. A dominant bit in intermission bits 1–2 flags an overload condition. A dominant bit in intermission bit 3, or any dominant bit during bus idle, flags a start of frame. It sits between the bit-timing unit, which supplies `samplePoint`, and the frame-maker state logic.

---
 rtl/inter_frame_space.sv | 51 +++++
 tb/tb_inter_frame_space.sv | 128 ++++++++++++
 2 files changed

// File: rtl/inter_frame_space.sv
// inter_frame_space: CAN interframe-space tracker; in samplePoint/reset_n/canRX/frameReady/endOverload, out isOverload (overload pending), isStart (1-cycle SOF pulse)
module inter_frame_space #(
  parameter int INTERMISSION_BITS = 3
) (
  input  logic samplePoint,
  input  logic reset_n,
  input  logic canRX,
  input  logic frameReady,
  input  logic endOverload,
  output logic isOverload,
  output logic isStart
);
  typedef enum logic [2:0] {WAIT_FRAME, INTERMISSION, BUS_IDLE, OVERLOAD, SOF} state_t;
  localparam int CW = INTERMISSION_BITS > 4 ? $clog2(INTERMISSION_BITS) : 2;
  localparam logic [CW-1:0] LAST = CW'(INTERMISSION_BITS - 1);
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  always_ff @(posedge samplePoint)
    if (!reset_n) begin
      state <= WAIT_FRAME;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  always_comb begin
    nstate = state;
    ncnt = cnt;
    case (state)
      WAIT_FRAME:
        if (frameReady) begin
          nstate = INTERMISSION;
          ncnt = '0;
        end
      INTERMISSION:
        if (!canRX) nstate = cnt == LAST ? SOF : OVERLOAD;
        else if (cnt == LAST) nstate = BUS_IDLE;
        else ncnt = cnt + CW'(1);
      BUS_IDLE: nstate = canRX ? BUS_IDLE : SOF;
      SOF: nstate = WAIT_FRAME;
      OVERLOAD:
        if (endOverload) begin
          nstate = INTERMISSION;
          ncnt = '0;
        end
      default: nstate = WAIT_FRAME;
    endcase
  end
  assign isOverload = state == OVERLOAD;
  assign isStart = state == SOF;
endmodule

// File: tb/tb_inter_frame_space.sv
// tb_inter_frame_space: table-driven and scoreboarded bench for inter_frame_space
module tb_inter_frame_space;
  logic samplePoint = 1'b0;
  logic reset_n = 1'b0;
  logic canRX = 1'b1;
  logic frameReady = 1'b0;
  logic endOverload = 1'b0;
  logic isOverload, isStart;
  int checks = 0;
  int errors = 0;
  typedef struct {string name; logic rn; logic rx; logic fr; logic eo; logic ovl; logic st;} vec_t;
  typedef struct {string name; logic ovl; logic st;} exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  inter_frame_space dut (
    .samplePoint(samplePoint),
    .reset_n(reset_n),
    .canRX(canRX),
    .frameReady(frameReady),
    .endOverload(endOverload),
    .isOverload(isOverload),
    .isStart(isStart)
  );
  always #5 samplePoint = ~samplePoint;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  function automatic void add(input string n, input logic rn, input logic rx, input logic fr, input logic eo, input logic ovl, input logic st);
    vec_t v;
    v.name = n; v.rn = rn; v.rx = rx; v.fr = fr; v.eo = eo; v.ovl = ovl; v.st = st;
    vecs.push_back(v);
  endfunction
  task automatic step(input string n, input logic rn, input logic rx, input logic fr, input logic eo, input logic ovl, input logic st);
    exp_t e;
    reset_n = rn;
    canRX = rx;
    frameReady = fr;
    endOverload = eo;
    e.name = n; e.ovl = ovl; e.st = st;
    sb.push_back(e);
    @(posedge samplePoint);
    #1;
    e = sb.pop_front();
    checks++;
    if (isOverload !== e.ovl) begin
      errors++;
      $display("FAIL %s isOverload got %b want %b", e.name, isOverload, e.ovl);
    end
    checks++;
    if (isStart !== e.st) begin
      errors++;
      $display("FAIL %s isStart got %b want %b", e.name, isStart, e.st);
    end
    checks++;
    if (isOverload === 1'b1 && isStart === 1'b1) begin
      errors++;
      $display("FAIL %s exclusive got both high want at most one", e.name);
    end
  endtask
  initial begin
    int n;
    add("rst", 0, 0, 1, 0, 0, 0);
    add("rst", 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) add("noframe", 1, 1'(i % 2), 0, 0, 0, 0);
    add("eo_ignored", 1, 0, 0, 1, 0, 0);
    add("idle_fr", 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("idle_im", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add("idle_bus", 1, 1, 1'(i % 2), 1'(i % 3 == 0), 0, 0);
    add("idle_sof", 1, 0, 0, 0, 0, 1);
    add("idle_after", 1, 1, 0, 0, 0, 0);
    add("idle_wait", 1, 0, 0, 0, 0, 0);
    add("b3_fr", 1, 0, 1, 0, 0, 0);
    add("b3_1", 1, 1, 0, 0, 0, 0);
    add("b3_2", 1, 1, 1, 0, 0, 0);
    add("b3_sof", 1, 0, 0, 0, 0, 1);
    add("b3_end", 1, 1, 0, 0, 0, 0);
    foreach (vecs[i]) step(vecs[i].name, vecs[i].rn, vecs[i].rx, vecs[i].fr, vecs[i].eo, vecs[i].ovl, vecs[i].st);
    step("ov_fr", 1, 1, 1, 0, 0, 0);
    step("ov_b1", 1, 1, 0, 0, 0, 0);
    step("ov_b2", 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step("ov_hold", 1, 1'(i % 2), 1, 0, 1, 0);
    step("ov_end", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("ov_im", 1, 1, 0, 0, 0, 0);
    step("ov_idle", 1, 1, 1, 1, 0, 0);
    step("ov_sof", 1, 0, 0, 0, 0, 1);
    step("ov_wait", 1, 1, 0, 0, 0, 0);
    step("cc_fr", 1, 1, 1, 0, 0, 0);
    step("cc_b1", 1, 0, 0, 0, 1, 0);
    step("cc_end", 1, 1, 0, 1, 0, 0);
    step("cc_b1b", 1, 0, 0, 0, 1, 0);
    step("cc_end2", 1, 0, 0, 1, 0, 0);
    step("cc_1", 1, 1, 0, 0, 0, 0);
    step("cc_2", 1, 1, 0, 0, 0, 0);
    step("cc_sof", 1, 0, 0, 0, 0, 1);
    step("cc_wait", 1, 1, 0, 0, 0, 0);
    step("ro_fr", 1, 1, 1, 0, 0, 0);
    step("ro_b1", 1, 0, 0, 0, 1, 0);
    step("ro_rst", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("ro_idle", 1, 0, 0, 1, 0, 0);
    step("ro_fr2", 1, 1, 1, 0, 0, 0);
    step("ro_b1b", 1, 0, 0, 0, 1, 0);
    step("ri_rst", 0, 0, 0, 0, 0, 0);
    step("ri_fr", 1, 1, 1, 0, 0, 0);
    step("ri_b1", 1, 1, 0, 0, 0, 0);
    step("ri_rst2", 0, 0, 1, 0, 0, 0);
    step("ri_after", 1, 0, 0, 0, 0, 0);
    step("ri_after2", 1, 0, 0, 0, 0, 0);
    step("lt_fr", 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("lt_im", 1, 1, 0, 0, 0, 0);
    canRX = 1'b0;
    n = 0;
    while (isStart !== 1'b1 && n < 5) begin
      @(posedge samplePoint);
      #1;
      n++;
    end
    checks++;
    if (n != 1 || isStart !== 1'b1) begin
      errors++;
      $display("FAIL lt_latency edges %0d isStart %b want 1 edge and 1", n, isStart);
    end
    step("lt_width", 1, 1, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
